// File: rtl/send_dispatch_ctrl.sv
// Transaction sequencer for the dual-channel send path: alternates stream beats
// between C0 and C1, then merges the per-channel completion pulses into one done pulse.
module send_dispatch_ctrl #(
  parameter int unsigned DATA_WD = 64,
  parameter int unsigned LEN_WD  = 32
) (
  input  logic               s_axis_aclk,
  input  logic               s_axis_aresetn,
  input  logic               start,
  input  logic               abort,
  input  logic [LEN_WD-1:0]  send_len,
  output logic               busy,
  output logic [LEN_WD-1:0]  data_cnt,
  output logic [LEN_WD-1:0]  tlast_cnt,
  output logic               err_early_last,
  output logic               s_axis_tready,
  input  logic [DATA_WD-1:0] s_axis_tdata,
  input  logic               s_axis_tlast,
  input  logic               s_axis_tvalid,
  output logic               m0_axis_tvalid,
  output logic [DATA_WD-1:0] m0_axis_tdata,
  input  logic               m0_axis_tready,
  output logic               m1_axis_tvalid,
  output logic [DATA_WD-1:0] m1_axis_tdata,
  input  logic               m1_axis_tready,
  input  logic               ch_done_C0,
  input  logic               ch_done_C1,
  output logic               o_tx_done
);

  typedef enum logic [1:0] {StIdle, StRun, StWaitDone, StDone} state_e;

  state_e              state_q, state_d;
  logic [LEN_WD-1:0]   len_q, len_d;
  logic [LEN_WD-1:0]   data_cnt_q, data_cnt_d;
  logic [LEN_WD-1:0]   tlast_cnt_q, tlast_cnt_d;
  logic                err_q, err_d;
  logic                sel_q, sel_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;

  logic                run_active;
  logic                beat_hs;
  logic [LEN_WD-1:0]   beat_next;
  logic                done0_now, done1_now;

  // Abort kills the input handshake in the same cycle so no beat slips through.
  assign run_active = (state_q == StRun) && !abort;
  assign beat_next  = data_cnt_q + LEN_WD'(1);
  assign done0_now  = done0_q | ch_done_C0;
  assign done1_now  = done1_q | ch_done_C1;

  always_comb begin
    s_axis_tready  = 1'b0;
    m0_axis_tvalid = 1'b0;
    m1_axis_tvalid = 1'b0;
    m0_axis_tdata  = '0;
    m1_axis_tdata  = '0;
    if (state_q == StRun) begin
      m0_axis_tdata = s_axis_tdata;
      m1_axis_tdata = s_axis_tdata;
    end
    if (run_active) begin
      m0_axis_tvalid = !sel_q && s_axis_tvalid;
      m1_axis_tvalid = sel_q && s_axis_tvalid;
      s_axis_tready  = sel_q ? m1_axis_tready : m0_axis_tready;
    end
  end

  assign beat_hs = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    data_cnt_d  = data_cnt_q;
    tlast_cnt_d = tlast_cnt_q;
    err_d       = err_q;
    sel_d       = sel_q;
    done0_d     = done0_q;
    done1_d     = done1_q;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          if (send_len != '0) begin
            len_d       = send_len;
            data_cnt_d  = '0;
            tlast_cnt_d = '0;
            err_d       = 1'b0;
            sel_d       = 1'b0;
            done0_d     = 1'b0;
            // C1 has no share of a single-beat transaction.
            done1_d     = (send_len == LEN_WD'(1));
            state_d     = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        done0_d = done0_now;
        done1_d = done1_now;
        if (beat_hs) begin
          data_cnt_d = beat_next;
          sel_d      = !sel_q;
          if (s_axis_tlast) begin
            tlast_cnt_d = tlast_cnt_q + LEN_WD'(1);
            if (beat_next < len_q) err_d = 1'b1;
          end
          if (beat_next == len_q) state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        done0_d = done0_now;
        done1_d = done1_now;
        if (done0_now && done1_now) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      done0_d = 1'b0;
      done1_d = 1'b0;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q     <= StIdle;
      len_q       <= '0;
      data_cnt_q  <= '0;
      tlast_cnt_q <= '0;
      err_q       <= 1'b0;
      sel_q       <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      data_cnt_q  <= data_cnt_d;
      tlast_cnt_q <= tlast_cnt_d;
      err_q       <= err_d;
      sel_q       <= sel_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
    end
  end

  assign busy           = (state_q != StIdle);
  assign data_cnt       = data_cnt_q;
  assign tlast_cnt      = tlast_cnt_q;
  assign err_early_last = err_q;
  assign o_tx_done      = (state_q == StDone) && !abort;

endmodule

// File: tb/tb_send_dispatch_ctrl.sv
// Directed bench for send_dispatch_ctrl: routing, stalls, early tlast, abort and reset.
module tb_send_dispatch_ctrl;
  localparam int DW = 64;
  localparam int LW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0;
  logic [LW-1:0] send_len = '0;
  logic          busy, err_early_last, s_axis_tready, o_tx_done;
  logic [LW-1:0] data_cnt, tlast_cnt;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0, s_axis_tvalid = 1'b0;
  logic          m0_axis_tvalid, m1_axis_tvalid;
  logic [DW-1:0] m0_axis_tdata, m1_axis_tdata;
  logic          m0_axis_tready = 1'b1, m1_axis_tready = 1'b1;
  logic          ch_done_C0 = 1'b0, ch_done_C1 = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int base;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  send_dispatch_ctrl #(.DATA_WD(DW), .LEN_WD(LW)) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .start(start), .abort(abort),
    .send_len(send_len), .busy(busy), .data_cnt(data_cnt), .tlast_cnt(tlast_cnt),
    .err_early_last(err_early_last), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .m0_axis_tvalid(m0_axis_tvalid), .m0_axis_tdata(m0_axis_tdata),
    .m0_axis_tready(m0_axis_tready), .m1_axis_tvalid(m1_axis_tvalid),
    .m1_axis_tdata(m1_axis_tdata), .m1_axis_tready(m1_axis_tready),
    .ch_done_C0(ch_done_C0), .ch_done_C1(ch_done_C1), .o_tx_done(o_tx_done)
  );

  always #5 clk = ~clk;

  // Inputs only change just after posedge, so negedge values match the next edge.
  always @(negedge clk) begin
    if (m0_axis_tvalid && m0_axis_tready) q0.push_back(m0_axis_tdata);
    if (m1_axis_tvalid && m1_axis_tready) q1.push_back(m1_axis_tdata);
    if (o_tx_done === 1'b1) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LW-1:0] len);
    q0.delete();
    q1.delete();
    start = 1'b1;
    send_len = len;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse(input logic c0, input logic c1);
    ch_done_C0 = c0;
    ch_done_C1 = c1;
    cyc();
    ch_done_C0 = 1'b0;
    ch_done_C1 = 1'b0;
  endtask

  // Beat i carries 0xA000+i; tlast where mask bit i is set; C1 stall while beat stall_beat waits.
  task automatic stream(input int n, input int mask, input int stall_beat, input int stall_n);
    int i = 0;
    int guard = 0;
    int stalls = 0;
    while (i < n && guard < 100) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 64'hA000 + 64'(i);
      s_axis_tlast = mask[i];
      m0_axis_tready = 1'b1;
      m1_axis_tready = 1'b1;
      if (i == stall_beat && stalls < stall_n) begin
        m1_axis_tready = 1'b0;
        stalls++;
      end
      #1;
      if (s_axis_tready) i++;
      cyc();
      guard++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    m1_axis_tready = 1'b1;
    n_tests++;
    if (i != n) begin n_fail++; $display("FAIL stream_timeout: accepted %0d beats, expected %0d", i, n); end
  endtask

  task automatic test_reset();
    s_axis_tdata = 64'hDEAD_BEEF;
    s_axis_tvalid = 1'b1;
    #12;
    n_tests++;
    if ({busy, s_axis_tready, m0_axis_tvalid, m1_axis_tvalid, o_tx_done, err_early_last} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000",
        {busy, s_axis_tready, m0_axis_tvalid, m1_axis_tvalid, o_tx_done, err_early_last});
    end
    n_tests++;
    if ({data_cnt, tlast_cnt, m0_axis_tdata, m1_axis_tdata} !== '0) begin
      n_fail++; $display("FAIL reset_data: cnt %0d tlast %0d m0 %h m1 %h expected all 0",
        data_cnt, tlast_cnt, m0_axis_tdata, m1_axis_tdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_zero_len();
    q0.delete();
    q1.delete();
    base = done_cnt;
    s_axis_tvalid = 1'b1;
    start = 1'b1;
    send_len = '0;
    #1;
    n_tests++;
    if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL zero_tready: got %b expected 0", s_axis_tready); end
    cyc();
    start = 1'b0;
    n_tests++;
    if (o_tx_done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b expected 1", o_tx_done); end
    n_tests++;
    if (data_cnt !== '0) begin n_fail++; $display("FAIL zero_data_cnt: got %0d expected 0", data_cnt); end
    cyc();
    s_axis_tvalid = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done_cnt - base != 1 || q0.size() + q1.size() != 0) begin
      n_fail++; $display("FAIL zero_end: busy %b pulses %0d beats %0d expected 0 1 0",
        busy, done_cnt - base, q0.size() + q1.size());
    end
  endtask

  task automatic test_basic();
    base = done_cnt;
    do_start(4);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 64'hA000;
    #1;
    n_tests++;
    if ({m0_axis_tvalid, m1_axis_tvalid} !== 2'b10 || m1_axis_tdata !== 64'hA000) begin
      n_fail++; $display("FAIL basic_route: valids %b m1_tdata %h expected 10 a000",
        {m0_axis_tvalid, m1_axis_tvalid}, m1_axis_tdata);
    end
    stream(4, 4'b1000, -1, 0);
    n_tests++;
    if (q0.size() != 2 || q1.size() != 2 || q0[0] !== 64'hA000 || q0[1] !== 64'hA002 ||
        q1[0] !== 64'hA001 || q1[1] !== 64'hA003) begin
      n_fail++; $display("FAIL basic_split: c0 %0d beats c1 %0d beats expected 2 2 (a000,a002 / a001,a003)",
        q0.size(), q1.size());
    end
    n_tests++;
    if (data_cnt !== 32'd4 || tlast_cnt !== 32'd1 || err_early_last !== 1'b0) begin
      n_fail++; $display("FAIL basic_counts: data %0d tlast %0d err %b expected 4 1 0",
        data_cnt, tlast_cnt, err_early_last);
    end
    s_axis_tvalid = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b1 || s_axis_tready !== 1'b0) begin
      n_fail++; $display("FAIL basic_wait: busy %b tready %b expected 1 0", busy, s_axis_tready);
    end
    s_axis_tvalid = 1'b0;
    pulse(1'b1, 1'b0);
    cyc();
    n_tests++;
    if (o_tx_done !== 1'b0) begin n_fail++; $display("FAIL basic_half_done: got %b expected 0", o_tx_done); end
    pulse(1'b0, 1'b1);
    n_tests++;
    if (o_tx_done !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_done: done %b busy %b expected 1 1", o_tx_done, busy);
    end
    cyc();
    n_tests++;
    if (o_tx_done !== 1'b0 || busy !== 1'b0 || done_cnt - base != 1) begin
      n_fail++; $display("FAIL basic_idle: done %b busy %b pulses %0d expected 0 0 1",
        o_tx_done, busy, done_cnt - base);
    end
  endtask

  task automatic test_single_beat();
    do_start(1);
    stream(1, 1, -1, 0);
    n_tests++;
    if (q0.size() != 1 || q1.size() != 0 || q0[0] !== 64'hA000) begin
      n_fail++; $display("FAIL single_split: c0 %0d c1 %0d expected 1 0", q0.size(), q1.size());
    end
    pulse(1'b1, 1'b0);
    n_tests++;
    if (o_tx_done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b expected 1", o_tx_done); end
    cyc();
  endtask

  task automatic test_back_to_back_stall();
    base = done_cnt;
    do_start(5);
    stream(5, 5'b10000, 1, 3);
    n_tests++;
    if (q0.size() != 3 || q1.size() != 2 || q0[0] !== 64'hA000 || q0[1] !== 64'hA002 ||
        q0[2] !== 64'hA004 || q1[0] !== 64'hA001 || q1[1] !== 64'hA003) begin
      n_fail++; $display("FAIL stall_split: c0 %0d c1 %0d expected 3 2 in order", q0.size(), q1.size());
    end
    n_tests++;
    if (data_cnt !== 32'd5 || tlast_cnt !== 32'd1) begin
      n_fail++; $display("FAIL stall_counts: data %0d tlast %0d expected 5 1", data_cnt, tlast_cnt);
    end
    pulse(1'b1, 1'b1);
    n_tests++;
    if (o_tx_done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b expected 1", o_tx_done); end
    repeat (3) cyc();
    n_tests++;
    if (done_cnt - base != 1) begin
      n_fail++; $display("FAIL stall_pulses: got %0d expected 1", done_cnt - base);
    end
  endtask

  task automatic test_early_last();
    do_start(6);
    stream(6, 6'b101000, -1, 0);
    n_tests++;
    if (data_cnt !== 32'd6 || tlast_cnt !== 32'd2 || err_early_last !== 1'b1) begin
      n_fail++; $display("FAIL early_counts: data %0d tlast %0d err %b expected 6 2 1",
        data_cnt, tlast_cnt, err_early_last);
    end
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    n_tests++;
    if (o_tx_done !== 1'b1) begin n_fail++; $display("FAIL early_done: got %b expected 1", o_tx_done); end
    cyc();
  endtask

  task automatic test_abort();
    do_start(8);
    stream(2, 0, -1, 0);
    base = done_cnt;
    s_axis_tvalid = 1'b1;
    abort = 1'b1;
    #1;
    n_tests++;
    if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL abort_tready: got %b expected 0", s_axis_tready); end
    cyc();
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || data_cnt !== 32'd2 || s_axis_tready !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: busy %b data %0d tready %b expected 0 2 0",
        busy, data_cnt, s_axis_tready);
    end
    s_axis_tvalid = 1'b0;
    abort = 1'b1;
    start = 1'b1;
    send_len = 32'd3;
    cyc();
    abort = 1'b0;
    start = 1'b0;
    repeat (2) cyc();
    n_tests++;
    if (busy !== 1'b0 || done_cnt != base) begin
      n_fail++; $display("FAIL abort_priority: busy %b pulses %0d expected 0 0", busy, done_cnt - base);
    end
    do_start(2);
    stream(2, 2'b10, -1, 0);
    n_tests++;
    if (data_cnt !== 32'd2 || tlast_cnt !== 32'd1 || err_early_last !== 1'b0 ||
        q0.size() != 1 || q1.size() != 1) begin
      n_fail++; $display("FAIL abort_rerun: data %0d tlast %0d err %b c0 %0d c1 %0d expected 2 1 0 1 1",
        data_cnt, tlast_cnt, err_early_last, q0.size(), q1.size());
    end
    pulse(1'b1, 1'b1);
    n_tests++;
    if (o_tx_done !== 1'b1) begin n_fail++; $display("FAIL abort_rerun_done: got %b expected 1", o_tx_done); end
    cyc();
  endtask

  task automatic test_reset_mid_run();
    do_start(8);
    stream(3, 0, -1, 0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 64'h55;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, s_axis_tready, m0_axis_tvalid, m1_axis_tvalid, o_tx_done, err_early_last} !== 6'b0) begin
      n_fail++; $display("FAIL midrst_flags: got %b expected 000000",
        {busy, s_axis_tready, m0_axis_tvalid, m1_axis_tvalid, o_tx_done, err_early_last});
    end
    n_tests++;
    if ({data_cnt, tlast_cnt, m0_axis_tdata, m1_axis_tdata} !== '0) begin
      n_fail++; $display("FAIL midrst_data: cnt %0d tlast %0d m0 %h m1 %h expected all 0",
        data_cnt, tlast_cnt, m0_axis_tdata, m1_axis_tdata);
    end
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_basic();
    test_single_beat();
    test_back_to_back_stall();
    test_early_last();
    test_abort();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/send_dispatch_ctrl.md
Name: send_dispatch_ctrl

Overview:
- Sequences one send transaction on the dual-channel PAICORE send path.
- Accepts a start command with a beat count and distributes incoming AXI-Stream beats alternately to channel C0 and channel C1, starting with C0.
- Collects the per-channel completion pulses and raises a single transaction-done pulse.
- Sits between the input stream FIFO and the two per-channel handshake senders.

Parameters:
DATA_WD, 64, stream data width in bits
LEN_WD, 32, width of send_len and of all counters

Ports:
s_axis_aclk  in  1  sole clock
s_axis_aresetn  in  1  asynchronous active-low reset
start  in  1  one-cycle start command; honoured only in IDLE
abort  in  1  synchronous abort; returns the block to IDLE
send_len  in  LEN_WD  total beats in the transaction; sampled on start
busy  out  1  high in every state except IDLE
data_cnt  out  LEN_WD  beats accepted in the current transaction
tlast_cnt  out  LEN_WD  accepted beats with tlast=1
err_early_last  out  1  sticky: tlast was seen before the final beat
s_axis_tready  out  1  input stream ready
s_axis_tdata  in  DATA_WD  input stream data
s_axis_tlast  in  1  input stream last
s_axis_tvalid  in  1  input stream valid
m0_axis_tvalid  out  1  channel C0 valid
m0_axis_tdata  out  DATA_WD  channel C0 data
m0_axis_tready  in  1  channel C0 ready
m1_axis_tvalid  out  1  channel C1 valid
m1_axis_tdata  out  DATA_WD  channel C1 data
m1_axis_tready  in  1  channel C1 ready
ch_done_C0  in  1  one-cycle pulse: C0 sender finished its share
ch_done_C1  in  1  one-cycle pulse: C1 sender finished its share
o_tx_done  out  1  one-cycle pulse: transaction complete

Behaviour:
- Reset is asynchronous and active-low. Every register clears on reset. All outputs are 0 in reset, and the FSM is in IDLE.
- FSM states: IDLE, RUN, WAIT_DONE, DONE.
- IDLE:
  - s_axis_tready=0; both m*_tvalid=0.
  - When start=1 and send_len!=0: latch len, clear data_cnt, tlast_cnt, err_early_last and both done flags, set sel=0, then go to RUN.
  - When start=1 and send_len=0: go to DONE without moving data.
- RUN routing (combinational, zero latency):
  - The selected channel gets m{sel}_tvalid = s_axis_tvalid and m{sel}_tdata = s_axis_tdata.
  - s_axis_tready = m{sel}_tready.
  - The unselected channel has tvalid=0, and its tdata holds s_axis_tdata.
- RUN handshake (s_axis_tvalid & s_axis_tready):
  - data_cnt increments and sel toggles.
  - tlast_cnt increments when tlast=1.
  - If tlast=1 and data_cnt+1 < len, err_early_last is set.
  - When data_cnt+1 == len, go to WAIT_DONE.
- Channel quotas: q0 = ceil(len/2), q1 = floor(len/2). A channel with quota 0 (C1 when len=1) counts as done at start.
- Done flags:
  - ch_done_Cx pulses are captured into sticky flags in RUN and WAIT_DONE.
  - Simultaneous pulses on both channels set both flags in the same cycle.
  - Pulses in IDLE and DONE are ignored.
- WAIT_DONE: s_axis_tready=0. When both flags are set (including the cycle they become set), go to DONE.
- DONE: o_tx_done=1 for exactly one cycle, then go to IDLE. Counters keep their values until the next start.
- abort:
  - In any state, the next state is IDLE and flags clear.
  - No o_tx_done pulse is generated.
  - s_axis_tready is forced to 0 in the abort cycle.
  - Counters keep their values.
  - abort has priority over start.
- start outside IDLE is ignored.
- Counters are LEN_WD bits wide. They cannot exceed len, so no wrap occurs.

Test Plan:
- start with send_len=4, tready tied 1, 4 beats, last beat tlast=1 -> beats 0,2 go to C0 and beats 1,3 to C1; data_cnt=4; tlast_cnt=1; err=0; WAIT_DONE. Then ch_done_C0 and ch_done_C1 pulsed in separate cycles -> o_tx_done one cycle after the later pulse reaches DONE; busy falls the cycle after.
- send_len=1 -> single beat to C0 only; ch_done_C0 alone -> o_tx_done.
- send_len=0 -> no tready; o_tx_done 1 cycle after start; data_cnt=0.
- send_len=5: m1_tready low for 3 cycles on beat 1 -> input stalls; no beat is lost or duplicated; C0 gets 3 beats, C1 gets 2; ch_done pulses arriving in the same cycle -> single o_tx_done.
- send_len=6 with tlast on beat 3 -> err_early_last=1; transfer still completes 6 beats; tlast_cnt counts all tlast beats.
- abort after 2 of 8 beats -> IDLE next cycle; tready=0; no o_tx_done. A new start with send_len=2 then runs cleanly. Async reset asserted mid-RUN -> all outputs 0 immediately.
